uart_wb_cmd_ctrl: RTL and testbench
===================================

Name: uart_wb_cmd_ctrl

Overview:
Command sequencer between the UART byte FIFOs and a Wishbone classic master port. Pops command frames from the RX FIFO and decodes them into single Wishbone read/write cycles. Pushes a response frame into the TX FIFO. Sole master of both FIFOs' pop/push sides and of the Wishbone bus.

Parameters:
ADDR_BYTES, 2, address bytes per frame; wb_adr_o width = 8*ADDR_BYTES
DATA_BYTES, 1, data bytes per frame; wb_dat width = 8*DATA_BYTES
TMO_CYC, 255, Wishbone ack timeout in clk cycles (1..65535)

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
rx_empty  in  1  RX FIFO empty
rx_pop  out  1  RX FIFO pop (combinational)
rx_data  in  8  RX FIFO data_out; valid the cycle after an accepted pop
tx_full  in  1  TX FIFO full
tx_push  out  1  TX FIFO push (combinational)
tx_data  out  8  TX FIFO data_in
wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe
wb_we_o  out  1  write enable
wb_adr_o  out  8*ADDR_BYTES  address
wb_dat_o  out  8*DATA_BYTES  write data
wb_dat_i  in  8*DATA_BYTES  read data
wb_ack_i  in  1  acknowledge
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; all wb_* outputs 0; tx_data 0; byte counter 0; busy 0; rx_pop/tx_push 0.
- Frame: cmd byte, then ADDR_BYTES address bytes MSB first, then (writes only) DATA_BYTES data bytes MSB first.
- Commands: 0x57 'W' = write, response 0x4B 'K'. 0x52 'R' = read, response DATA_BYTES bytes MSB first. Any other value: response 0x3F '?', no further bytes consumed.
- Timeout response: 0x54 'T'.
- Byte fetch, two states:
  - FETCH: rx_pop = !rx_empty; advance to LATCH only when the pop is accepted.
  - LATCH: capture rx_data; FIFO output is registered, so data is valid one cycle after pop. No pop in LATCH.
  - Minimum 2 cycles/byte.
- States: IDLE -> FETCH(cmd) -> LATCH(cmd) -> {ADDR fetch/latch loop, cnt 0..ADDR_BYTES-1} -> {DATA loop, write only} -> WB -> RESP -> IDLE.
  - Unknown cmd: LATCH(cmd) -> RESP.
  - IDLE -> FETCH when !rx_empty.
- WB state:
  - cyc=stb=1, we per command, adr/dat held stable.
  - On wb_ack_i: deassert cyc/stb the next cycle; latch wb_dat_i for reads.
  - Timeout counter counts cycles in WB. When it reaches TMO_CYC without ack: drop cyc/stb, respond 'T'.
  - A late ack is ignored.
- RESP:
  - tx_push = !tx_full; tx_data is registered and holds the current response byte.
  - Advance byte counter only on an accepted push.
  - Stall indefinitely while tx_full.
  - Read response bytes are taken from the data latched at ack.
- Sampling: rx_empty is sampled only in FETCH and tx_full only in RESP. Simultaneous rx activity during WB/RESP is not consumed.
- Partial frame: waits in FETCH forever; there is no inter-byte timeout.
- nrst low mid-operation:
  - Immediate return to IDLE; wb_cyc_o drops in the same edge.
  - Partial frame bytes already popped are lost.
- Widths: byte counter ceil(log2(max(ADDR_BYTES,DATA_BYTES)+1)) bits. Timeout counter 16 bits, saturating compare.

Optional Feature:
UWB_ERR_EN
- Defined:
  - Adds input wb_err_i (1 bit).
  - wb_err_i in WB state terminates the cycle like ack and responds 0x45 'E', for reads as well (no data bytes).
  - If ack and err are both high, err wins.
- Undefined: no port; error termination is not possible, so only ack or timeout.

Decomposition:
- Package uwb_pkg holds:
  - state enum: IDLE, FETCH, LATCH, WB, RESP;
  - phase enum: CMD, ADDR, DATA;
  - command/response byte constants: CMD_WR, CMD_RD, RSP_OK, RSP_BAD, RSP_TMO, RSP_ERR.
- One natural sub-module: uwb_tmo_cnt, the clear/enable/terminal-count timeout counter.

Test Plan:
- Write: RX holds 57 12 34 A5 (ADDR_BYTES=2); slave acks after 3 cycles -> one WB cycle, we=1, adr=0x1234, dat_o=0xA5; TX receives 4B; busy returns to 0.
- Read: RX holds 52 00 10, slave returns 0x5C with ack -> we=0, adr=0x0010; TX receives 5C.
- Bad command: RX holds 41 52 00 01 -> TX receives 3F; the following 52 00 01 executes as a read.
- Timeout, TMO_CYC=8, no ack -> cyc drops after 8 WB cycles; TX receives 54; an ack injected 2 cycles later has no effect.
- Backpressure: tx_full held 20 cycles during a read response -> tx_push=0 throughout, tx_data stable; the byte is pushed on the first cycle tx_full=0.
- Reset: nrst pulsed low while in WB state -> wb_cyc_o=0 next edge, state IDLE; the next full frame executes correctly.
- UWB_ERR_EN build: wb_err_i during a write -> TX receives 45.

Source files
------------

// File: rtl/uwb_pkg.sv
// Shared types and byte constants for the UART-to-Wishbone command sequencer.
package uwb_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WB,
    RESP
  } state_e;

  // Which part of the frame the fetch/latch loop is collecting
  typedef enum logic [1:0] {
    CMD,
    ADDR,
    DATA
  } phase_e;

  // Command bytes
  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'

  // Response bytes
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_BAD = 8'h3F;  // '?'
  localparam logic [7:0] RSP_TMO = 8'h54;  // 'T'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

  // Byte counter width: must hold 0..max(addr_bytes, data_bytes)
  function automatic int cnt_width(input int addr_bytes, input int data_bytes);
    int m;
    m = (addr_bytes > data_bytes) ? addr_bytes : data_bytes;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uwb_tmo_cnt.sv
// Wishbone ack timeout counter: clear, count-enable and terminal-count flag.
// 16-bit saturating count; tc_o asserts in the TMO_CYC-th enabled cycle
// after a clear, so the caller can terminate on that same clock edge.
module uwb_tmo_cnt #(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [15:0] TC_VAL = 16'(TMO_CYC - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear wins, then saturating increment while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q >= TC_VAL);

endmodule

// File: rtl/uart_wb_cmd_ctrl.sv
// Command sequencer: pops command frames from the RX byte FIFO, runs one
// Wishbone classic cycle per frame and pushes the response into the TX FIFO.
// Optional build macro UWB_ERR_EN adds wb_err_i: an error termination that
// answers 'E' and takes priority over a simultaneous ack.
module uart_wb_cmd_ctrl
  import uwb_pkg::*;
#(
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 1,
  parameter int TMO_CYC    = 255
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    rx_empty,
  output logic                    rx_pop,
  input  logic [7:0]              rx_data,
  input  logic                    tx_full,
  output logic                    tx_push,
  output logic [7:0]              tx_data,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [8*ADDR_BYTES-1:0] wb_adr_o,
  output logic [8*DATA_BYTES-1:0] wb_dat_o,
  input  logic [8*DATA_BYTES-1:0] wb_dat_i,
  input  logic                    wb_ack_i,
`ifdef UWB_ERR_EN
  input  logic                    wb_err_i,
`endif
  output logic                    busy
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = cnt_width(ADDR_BYTES, DATA_BYTES);

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;        // byte index within address/data/response
  logic            is_wr_q, is_wr_d;    // decoded command is a write
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [DW-1:0]   rsp_q, rsp_d;        // response bytes, current byte in the top lane
  logic [CW-1:0]   rsp_last_q, rsp_last_d;

  logic            err_w;
  logic            tmo_clr;
  logic            tmo_en;
  logic            tmo_tc;

`ifdef UWB_ERR_EN
  assign err_w = wb_err_i;
`else
  assign err_w = 1'b0;
`endif

  // Single response byte placed in the lane that drives tx_data
  function automatic logic [DW-1:0] rsp_byte(input logic [7:0] b);
    logic [DW-1:0] r;
    r = '0;
    r[DW-1 -: 8] = b;
    return r;
  endfunction

  // The timeout counter restarts every time the WB state is entered
  assign tmo_clr = (state_q != WB);
  assign tmo_en  = (state_q == WB);

  uwb_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo_cnt (
    .clk   (clk),
    .nrst  (nrst),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  // Next-state logic plus the combinational FIFO handshakes
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    rsp_d      = rsp_q;
    rsp_last_d = rsp_last_q;
    rx_pop     = 1'b0;
    tx_push    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_empty) begin
          state_d = FETCH;
          phase_d = CMD;
          cnt_d   = '0;
        end
      end

      FETCH: begin
        // Pop only when data is available; the byte appears next cycle
        rx_pop = !rx_empty;
        if (!rx_empty) begin
          state_d = LATCH;
        end
      end

      LATCH: begin
        case (phase_q)
          CMD: begin
            is_wr_d = (rx_data == CMD_WR);
            if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
              phase_d = ADDR;
              cnt_d   = '0;
              state_d = FETCH;
            end else begin
              // Unknown command: answer '?' and leave the rest of RX alone
              rsp_d      = rsp_byte(RSP_BAD);
              rsp_last_d = '0;
              cnt_d      = '0;
              state_d    = RESP;
            end
          end

          ADDR: begin
            adr_d = (adr_q << 8) | AW'(rx_data);
            if (cnt_q == ADDR_LAST) begin
              cnt_d = '0;
              if (is_wr_q) begin
                phase_d = DATA;
                state_d = FETCH;
              end else begin
                state_d = WB;
                cyc_d   = 1'b1;
                we_d    = 1'b0;
              end
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
              state_d = FETCH;
            end
          end

          DATA: begin
            wdat_d = (wdat_q << 8) | DW'(rx_data);
            if (cnt_q == DATA_LAST) begin
              cnt_d   = '0;
              state_d = WB;
              cyc_d   = 1'b1;
              we_d    = 1'b1;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
              state_d = FETCH;
            end
          end

          default: begin
            state_d = IDLE;
          end
        endcase
      end

      WB: begin
        // Error beats ack, ack beats timeout; any of them ends the cycle
        if (err_w || wb_ack_i || tmo_tc) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          cnt_d      = '0;
          state_d    = RESP;
          rsp_last_d = '0;
          if (err_w) begin
            rsp_d = rsp_byte(RSP_ERR);
          end else if (wb_ack_i) begin
            if (is_wr_q) begin
              rsp_d = rsp_byte(RSP_OK);
            end else begin
              rsp_d      = wb_dat_i;
              rsp_last_d = DATA_LAST;
            end
          end else begin
            rsp_d = rsp_byte(RSP_TMO);
          end
        end
      end

      RESP: begin
        tx_push = !tx_full;
        if (!tx_full) begin
          if (cnt_q == rsp_last_q) begin
            // Last byte gone: keep it on tx_data and return to idle
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            rsp_d = rsp_q << 8;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      phase_q    <= CMD;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      rsp_q      <= '0;
      rsp_last_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      rsp_q      <= rsp_d;
      rsp_last_q <= rsp_last_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = wdat_q;
  assign tx_data  = rsp_q[DW-1 -: 8];
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_wb_cmd_ctrl.sv
// Self-checking bench for uart_wb_cmd_ctrl (ADDR_BYTES=2, DATA_BYTES=1, TMO_CYC=8).
`timescale 1ns/1ps
module tb_uart_wb_cmd_ctrl;
  import uwb_pkg::*;

  localparam int AB  = 2;
  localparam int DB  = 1;
  localparam int TMO = 8;
  localparam int AW  = 8 * AB;
  localparam int DW  = 8 * DB;

  typedef logic [7:0] byte_t;
  typedef byte_t byte_q_t[$];

  typedef struct {
    bit            we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    int            len;
  } wb_exp_t;

  typedef struct {
    bit            ack;
    int            dly;
    logic [DW-1:0] rd;
    bit            err;
  } plan_t;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          rx_empty = 1'b1;
  logic          rx_pop;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_full;
  logic          tx_push;
  logic [7:0]    tx_data;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
`ifdef UWB_ERR_EN
  logic          wb_err_i;
`endif
  logic          busy;

  int checks = 0;
  int failures = 0;

  byte_t   rx_q[$];
  byte_t   exp_tx[$];
  wb_exp_t exp_wb[$];
  plan_t   plan_q[$];

  bit rand_full = 0, force_full = 0, inject_ack = 0, abort = 0, mon_en = 0;
  bit s_active = 0;
  int s_age = 0;
  plan_t s_plan;

  wb_exp_t       cur;
  bit            cur_ok = 0, cyc_prev = 0;
  int            cyc_len = 0, last_len = 0;
  byte_t         last_tx = 8'h00;
  logic [AW-1:0] last_adr = '0;
  logic [DW-1:0] last_dat = '0;
  bit            last_we = 0;

  uart_wb_cmd_ctrl #(
    .ADDR_BYTES (AB),
    .DATA_BYTES (DB),
    .TMO_CYC    (TMO)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .rx_empty (rx_empty),
    .rx_pop   (rx_pop),
    .rx_data  (rx_data),
    .tx_full  (tx_full),
    .tx_push  (tx_push),
    .tx_data  (tx_data),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
`ifdef UWB_ERR_EN
    .wb_err_i (wb_err_i),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_line(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    failures++;
    $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: what one frame must produce on Wishbone and on TX.
  // dly = cycle (1-based) in which the slave answers; 0 = slave never answers.
  task automatic model_frame(input byte_q_t fr, input int dly, input logic [DW-1:0] rd, input bit err);
    wb_exp_t e;
    plan_t p;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (fr[0] != CMD_WR && fr[0] != CMD_RD) begin
      exp_tx.push_back(RSP_BAD);
      return;
    end
    a = '0;
    for (int i = 0; i < AB; i++) a = (a << 8) | AW'(fr[1+i]);
    d = '0;
    if (fr[0] == CMD_WR) for (int i = 0; i < DB; i++) d = (d << 8) | DW'(fr[1+AB+i]);
    e.we = (fr[0] == CMD_WR); e.adr = a; e.dat = d; e.len = (dly == 0) ? TMO : dly;
    exp_wb.push_back(e);
    p.ack = (dly != 0); p.dly = dly; p.rd = rd; p.err = err;
    plan_q.push_back(p);
    if (err && dly != 0)      exp_tx.push_back(RSP_ERR);
    else if (dly == 0)        exp_tx.push_back(RSP_TMO);
    else if (fr[0] == CMD_WR) exp_tx.push_back(RSP_OK);
    else for (int i = 0; i < DB; i++) exp_tx.push_back(rd[8*(DB-1-i) +: 8]);
  endtask

  task automatic feed(input byte_q_t fr);
    int n;
    foreach (fr[i]) begin
      rx_q.push_back(fr[i]);
      n = $urandom_range(0, 2);
      repeat (n) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_cyc(input logic v, input string name);
    int n = 0;
    while (wb_cyc_o !== v && n < 300) begin @(posedge clk); #1; n++; end
    if (wb_cyc_o !== v) fail_line(name, 32'(wb_cyc_o), 32'(v));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || rx_q.size() != 0 || busy) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 1000) begin
      fail_line({name, "_timeout"}, 32'(exp_tx.size()), 0);
      exp_tx.delete(); exp_wb.delete(); plan_q.delete();
    end
    @(negedge clk);
    check({name, "_busy_idle"}, 32'(busy), 0);
    check({name, "_wb_started"}, 32'(exp_wb.size()), 0);
  endtask

  // RX FIFO with registered output
  always @(posedge clk) begin
    if (rx_pop && !rx_empty && rx_q.size() > 0) rx_data <= rx_q.pop_front();
    rx_empty <= (rx_q.size() == 0);
  end

  // Wishbone slave and tx_full driver, inputs change 1 ns after the edge
  initial begin
    wb_ack_i = 1'b0; wb_dat_i = '0; tx_full = 1'b0;
`ifdef UWB_ERR_EN
    wb_err_i = 1'b0;
`endif
    forever begin
      @(posedge clk); #1;
      tx_full  = rand_full ? ($urandom_range(0, 2) == 0) : force_full;
      wb_ack_i = 1'b0;
      wb_dat_i = DW'($urandom);
`ifdef UWB_ERR_EN
      wb_err_i = 1'b0;
`endif
      if (wb_cyc_o && nrst) begin
        if (!s_active) begin
          s_active = 1; s_age = 0;
          if (plan_q.size() > 0) s_plan = plan_q.pop_front();
          else begin s_plan.ack = 0; s_plan.dly = 0; s_plan.rd = '0; s_plan.err = 0; end
        end
        s_age++;
        if (s_plan.ack && s_age == s_plan.dly) begin
          wb_ack_i = 1'b1;
          wb_dat_i = s_plan.rd;
`ifdef UWB_ERR_EN
          if (s_plan.err) wb_err_i = 1'b1;
`endif
        end
      end else begin
        s_active = 0;
        if (inject_ack) begin wb_ack_i = 1'b1; inject_ack = 0; end
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the model queues
  initial begin
    byte_t e8;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rx_pop) check("rx_pop_vs_empty", 32'(rx_empty), 0);
        if (tx_push) begin
          check("tx_push_vs_full", 32'(tx_full), 0);
          if (!tx_full) begin
            if (exp_tx.size() == 0) fail_line("tx_unexpected_byte", 32'(tx_data), 0);
            else begin
              e8 = exp_tx.pop_front();
              check("tx_data", 32'(tx_data), 32'(e8));
              last_tx = tx_data;
            end
          end
        end
        check("wb_stb_vs_cyc", 32'(wb_stb_o), 32'(wb_cyc_o));
        if (wb_cyc_o) begin
          check("busy_during_wb", 32'(busy), 1);
          if (!cyc_prev) begin
            cyc_len = 1;
            if (exp_wb.size() == 0) begin
              fail_line("wb_unexpected_cycle", 32'(wb_adr_o), 0);
              cur_ok = 0;
            end else begin
              cur = exp_wb.pop_front();
              cur_ok = 1;
              check("wb_we", 32'(wb_we_o), 32'(cur.we));
              check("wb_adr", 32'(wb_adr_o), 32'(cur.adr));
              if (cur.we) check("wb_dat_o", 32'(wb_dat_o), 32'(cur.dat));
              last_adr = wb_adr_o; last_we = wb_we_o; last_dat = wb_dat_o;
            end
          end else begin
            cyc_len++;
            if (cur_ok) begin
              check("wb_adr_stable", 32'(wb_adr_o), 32'(cur.adr));
              check("wb_we_stable", 32'(wb_we_o), 32'(cur.we));
              if (cur.we) check("wb_dat_stable", 32'(wb_dat_o), 32'(cur.dat));
            end
          end
        end else if (cyc_prev) begin
          if (abort) abort = 0;
          else if (cur_ok) check("wb_cyc_len", 32'(cyc_len), 32'(cur.len));
          last_len = cyc_len;
        end
      end
      cyc_prev = wb_cyc_o;
    end
  end

  // Stimulus
  initial begin
    byte_q_t fr;
    byte_t c;
    int dly;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_cyc", 32'(wb_cyc_o), 0);
    check("rst_stb", 32'(wb_stb_o), 0);
    check("rst_we", 32'(wb_we_o), 0);
    check("rst_adr", 32'(wb_adr_o), 0);
    check("rst_dat_o", 32'(wb_dat_o), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_tx_push", 32'(tx_push), 0);
    check("rst_rx_pop", 32'(rx_pop), 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    mon_en = 1;

    // Write, slave acks in cycle 3
    fr = {8'h57, 8'h12, 8'h34, 8'hA5};
    model_frame(fr, 3, '0, 0); feed(fr); wait_done("write");
    check("write_tx_K", 32'(last_tx), 32'h4B);
    check("write_adr", 32'(last_adr), 32'h1234);
    check("write_we", 32'(last_we), 1);
    check("write_dat", 32'(last_dat), 32'hA5);
    check("write_len", 32'(last_len), 3);
    $display("txn write adr=%0h dat=%0h rsp=%0h", last_adr, last_dat, last_tx);

    // Read returning 0x5C
    fr = {8'h52, 8'h00, 8'h10};
    model_frame(fr, 2, 8'h5C, 0); feed(fr); wait_done("read");
    check("read_tx_data", 32'(last_tx), 32'h5C);
    check("read_adr", 32'(last_adr), 32'h0010);
    check("read_we", 32'(last_we), 0);
    $display("txn read adr=%0h rsp=%0h", last_adr, last_tx);

    // Bad command followed by a valid read in the same RX burst
    fr = {8'h41};
    model_frame(fr, 0, '0, 0);
    fr = {8'h52, 8'h00, 8'h01};
    model_frame(fr, 1, 8'h77, 0);
    fr = {8'h41, 8'h52, 8'h00, 8'h01};
    feed(fr); wait_done("badcmd");
    check("badcmd_next_read", 32'(last_tx), 32'h77);
    check("badcmd_next_adr", 32'(last_adr), 32'h0001);
    $display("txn badcmd then read adr=%0h rsp=%0h", last_adr, last_tx);

    // Timeout with a late ack two cycles after the cycle ends
    fr = {8'h52, 8'h00, 8'h22};
    model_frame(fr, 0, '0, 0); feed(fr);
    wait_cyc(1'b1, "tmo_cyc_rise");
    wait_cyc(1'b0, "tmo_cyc_fall");
    repeat (2) @(negedge clk);
    inject_ack = 1;
    repeat (4) @(posedge clk);
    #1;
    wait_done("timeout");
    check("tmo_len", 32'(last_len), 8);
    check("tmo_tx_T", 32'(last_tx), 32'h54);
    $display("txn timeout len=%0d rsp=%0h", last_len, last_tx);

    // Backpressure: TX full for 20 cycles during a read response
    force_full = 1;
    fr = {8'h52, 8'h00, 8'h10};
    model_frame(fr, 2, 8'h5C, 0); feed(fr);
    wait_cyc(1'b1, "bp_cyc_rise");
    wait_cyc(1'b0, "bp_cyc_fall");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_no_push", 32'(tx_push), 0);
      check("bp_data_stable", 32'(tx_data), 32'h5C);
    end
    force_full = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_push_on_release", 32'(tx_push), 1);
    wait_done("backpressure");
    $display("txn backpressure rsp=%0h", last_tx);

    // Reset while the Wishbone cycle is open
    fr = {8'h52, 8'h00, 8'h33};
    model_frame(fr, 0, '0, 0); feed(fr);
    wait_cyc(1'b1, "rst_cyc_rise");
    repeat (2) begin @(posedge clk); #1; end
    abort = 1;
    nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_cyc", 32'(wb_cyc_o), 0);
    check("rst_mid_busy", 32'(busy), 0);
    exp_tx.delete(); plan_q.delete(); exp_wb.delete();
    @(posedge clk); #1;
    nrst = 1'b1;
    fr = {8'h57, 8'hAB, 8'hCD, 8'h3C};
    model_frame(fr, 2, '0, 0); feed(fr); wait_done("after_reset");
    check("after_rst_adr", 32'(last_adr), 32'hABCD);
    check("after_rst_tx", 32'(last_tx), 32'h4B);
    $display("txn after reset adr=%0h rsp=%0h", last_adr, last_tx);

`ifdef UWB_ERR_EN
    // Error termination during a write, ack asserted together with err
    fr = {8'h57, 8'h00, 8'h44, 8'h99};
    model_frame(fr, 2, '0, 1); feed(fr); wait_done("err");
    check("err_tx_E", 32'(last_tx), 32'h45);
    $display("txn error rsp=%0h", last_tx);
`endif

    // Randomized frames with random TX backpressure and slave latency
    rand_full = 1;
    for (int f = 0; f < 40; f++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) c = CMD_WR;
      else if (r < 8) c = CMD_RD;
      else begin
        c = 8'($urandom);
        while (c == CMD_WR || c == CMD_RD) c = 8'($urandom);
      end
      fr = {c};
      if (c == CMD_WR || c == CMD_RD) for (int i = 0; i < AB; i++) fr.push_back(8'($urandom));
      if (c == CMD_WR) for (int i = 0; i < DB; i++) fr.push_back(8'($urandom));
      dly = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, TMO - 1);
      model_frame(fr, dly, DW'($urandom), 0);
      feed(fr);
      wait_done("random");
      $display("txn random %0d cmd=%0h dly=%0d rsp=%0h", f, c, dly, last_tx);
    end
    rand_full = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
